// File: rtl/morsecode_symbol_player.sv
// Plays one Morse letter (MSB-first dot/dash pattern) on a single line, timed by an external unit strobe.
// Marks and inter-symbol gaps are counted in ticks; the letter length is tracked locally.
module morsecode_symbol_player #(
  parameter int MAX_LEN    = 4,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         length,
  input  logic               tick,
  output logic               led,
  output logic               busy,
  output logic               done,
  output logic [3:0]         remaining
);

  localparam int MAX_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int CNT_W     = $clog2(MAX_UNITS + 1);

  localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_UNITS);
  localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(1);
  localparam logic [3:0]       MAX_LEN_4 = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, MARK, GAP, FINISH} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   unit_cnt;
  logic [MAX_LEN-1:0] shift_reg;
  logic [3:0]         len_clamped;
  logic               unit_end;
  logic               led_next;
  logic               busy_next;
  logic               done_next;

  assign len_clamped = (length > MAX_LEN_4) ? MAX_LEN_4 : length;
  assign unit_end    = tick && (unit_cnt == DOT_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      led   <= led_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len_clamped == 4'd0) ? FINISH : MARK;
        end
      end
      MARK: begin
        if (unit_end) begin
          state_next = (remaining == 4'd1) ? FINISH : GAP;
        end
      end
      GAP: begin
        if (unit_end) begin
          state_next = MARK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    led_next  = (state_next == MARK);
    busy_next = (state_next != IDLE);
    done_next = (state_next == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_cnt  <= '0;
      shift_reg <= '0;
      remaining <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= pattern;
            remaining <= len_clamped;
            if (len_clamped != 4'd0) begin
              unit_cnt <= pattern[MAX_LEN-1] ? DASH_LOAD : DOT_LOAD;
            end
          end
        end
        MARK: begin
          if (unit_end) begin
            shift_reg <= shift_reg << 1;
            remaining <= remaining - 4'd1;
            unit_cnt  <= (remaining == 4'd1) ? '0 : GAP_LOAD;
          end else if (tick) begin
            unit_cnt <= unit_cnt - DOT_LOAD;
          end
        end
        GAP: begin
          // The register was already shifted, so its MSB is the next symbol.
          if (unit_end) begin
            unit_cnt <= shift_reg[MAX_LEN-1] ? DASH_LOAD : DOT_LOAD;
          end else if (tick) begin
            unit_cnt <= unit_cnt - DOT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morsecode_symbol_player.sv
// Randomised scoreboard bench for morsecode_symbol_player: a segment-level model predicts
// every busy cycle of each letter, and a monitor compares the DUT against that queue.
module tb_morsecode_symbol_player;

  localparam int MAX_LEN    = 4;
  localparam int DASH_UNITS = 3;
  localparam int GAP_UNITS  = 1;

  typedef struct {
    logic       led;
    logic       busy;
    logic       done;
    logic [3:0] rem;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] pattern = 4'd0;
  logic [3:0] length = 4'd0;
  logic       led;
  logic       busy;
  logic       done;
  logic [3:0] remaining;

  int   total = 0;
  int   bad = 0;
  int   edge_no = 0;
  int   tick_period = 1;
  int   tick_phase = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  morsecode_symbol_player #(
    .MAX_LEN(MAX_LEN),
    .DASH_UNITS(DASH_UNITS),
    .GAP_UNITS(GAP_UNITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pattern(pattern),
    .length(length),
    .tick(tick),
    .led(led),
    .busy(busy),
    .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic bit tick_at(int n);
    if (tick_period <= 1) return 1'b1;
    return (n % tick_period) == tick_phase;
  endfunction

  // The tick seen at edge n is driven during the half cycle before it.
  always @(negedge clk) tick = tick_at(edge_no + 1);

  task automatic check_output(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %0d want %0d", name, edge_no, act, want);
    end
  endtask

  // Edge at which a segment of u units that began at edge b finishes.
  function automatic int seg_end(int b, int u);
    int e = b;
    int c = 0;
    while (c < u) begin
      e++;
      if (tick_at(e)) c++;
    end
    return e;
  endfunction

  task automatic push_span(input int from, input int to, input logic l, input logic [3:0] r);
    for (int k = from; k < to; k++) exp_q.push_back(exp_t'{l, 1'b1, 1'b0, r});
  endtask

  // Letter = list of (mark, gap) segments; each cycle between boundaries gets one record.
  task automatic push_expected(input logic [3:0] pat, input int len, input int s);
    int n;
    int e;
    int e_end;
    int units;
    logic [3:0] p;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    e = s;
    p = pat;
    for (int i = 0; i < n; i++) begin
      units = p[MAX_LEN-1-i] ? DASH_UNITS : 1;
      e_end = seg_end(e, units);
      push_span(e, e_end, 1'b1, 4'(n - i));
      e = e_end;
      if (i < n - 1) begin
        e_end = seg_end(e, GAP_UNITS);
        push_span(e, e_end, 1'b0, 4'(n - i - 1));
        e = e_end;
      end
    end
    exp_q.push_back(exp_t'{1'b0, 1'b1, 1'b1, 4'd0});
  endtask

  task automatic apply_stimulus(input logic [3:0] pat, input logic [3:0] len);
    @(negedge clk);
    start   = 1'b1;
    pattern = pat;
    length  = len;
    push_expected(pat, int'(len), edge_no + 1);
    @(negedge clk);
    start   = 1'b0;
    pattern = 4'($urandom);
    length  = 4'($urandom);
  endtask

  task automatic wait_letter();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d records still pending, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: while records are pending each cycle is compared; otherwise the DUT must be idle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("led", int'(led), int'(e.led));
        check_output("busy", int'(busy), int'(e.busy));
        check_output("done", int'(done), int'(e.done));
        check_output("remaining", int'(remaining), int'(e.rem));
      end else begin
        check_output("idle_led", int'(led), 0);
        check_output("idle_busy", int'(busy), 0);
        check_output("idle_done", int'(done), 0);
        check_output("idle_remaining", int'(remaining), 0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_led", int'(led), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_remaining", int'(remaining), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Letter A with a tick every 4 clocks.
    tick_period = 4;
    tick_phase = 1;
    apply_stimulus(4'b0100, 4'd2);
    wait_letter();

    // Letter H with tick held high.
    tick_period = 1;
    apply_stimulus(4'b0000, 4'd4);
    wait_letter();

    // Empty letter.
    apply_stimulus(4'b1010, 4'd0);
    wait_letter();

    // Over-long length clamps to four dashes.
    tick_period = 2;
    tick_phase = 0;
    apply_stimulus(4'b1111, 4'd9);
    wait_letter();

    // Letter B with a second start during its second symbol.
    tick_period = 1;
    apply_stimulus(4'b1000, 4'd4);
    repeat (4) @(negedge clk);
    start = 1'b1;
    pattern = 4'b1111;
    length = 4'd4;
    @(negedge clk);
    start = 1'b0;
    wait_letter();

    // Letter T abandoned by an asynchronous reset in the middle of its dash.
    apply_stimulus(4'b1000, 4'd1);
    @(negedge clk);
    mon_en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #2;
    check_output("mid_dash_led", int'(led), 1);
    #1;
    rst = 1'b1;
    #1;
    check_output("async_rst_led", int'(led), 0);
    check_output("async_rst_busy", int'(busy), 0);
    check_output("async_rst_remaining", int'(remaining), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(4'b1000, 4'd1);
    wait_letter();

    // Random letters under random tick rates.
    for (int i = 0; i < 16; i++) begin
      tick_period = $urandom_range(1, 4);
      tick_phase = $urandom_range(0, tick_period - 1);
      repeat (1) @(negedge clk);
      apply_stimulus(4'($urandom), 4'($urandom_range(0, 15)));
      wait_letter();
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
